// File: rtl/vga_timing_if.sv
// ----------------------------------------------------------------------------
// vga_timing_if
//   Raster timing bundle produced by vga_timing_gen and consumed by the pixel
//   pipeline.
//   Signals:
//     hsync, vsync   sync levels (polarity chosen by the generator)
//     visible        1 while (x,y) is inside the visible region
//     x, y           current horizontal / vertical count, CW bits each
//     line_start     one-clk pulse when x becomes 0
//     frame_start    one-clk pulse when (x,y) becomes (0,0)
//   Modports:
//     master         the timing generator (drives everything)
//     slave          a consumer (reads everything)
// ----------------------------------------------------------------------------
interface vga_timing_if #(
    parameter int CW = 10
);
    logic          hsync;
    logic          vsync;
    logic          visible;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output hsync, vsync, visible, x, y, line_start, frame_start
    );

    modport slave (
        input hsync, vsync, visible, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator. Advances a horizontal/vertical pixel counter on
//   every clk where pix_en is high and produces registered sync, visible,
//   coordinate and line/frame start outputs describing the new position.
//   Ports:
//     clk     in   system clock
//     nrst    in   synchronous reset, active-low
//     pix_en  in   pixel-clock enable, one pixel per enabled clk
//     vga     master modport of vga_timing_if (hsync, vsync, visible, x, y,
//             line_start, frame_start)
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CW        = 10
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            pix_en,
    vga_timing_if.master    vga
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = H_VISIBLE + H_FRONT + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = V_VISIBLE + V_FRONT + V_SYNC;

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [CW-1:0] x_q, y_q;
    logic          hsync_q, vsync_q, visible_q;
    logic          line_start_q, frame_start_q;

    logic          hs_act_d, vs_act_d, visible_d;

    // Next counter position; counters park at (H_TOTAL-1, V_TOTAL-1) in reset
    // so the first enabled pixel lands on (0,0).
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (pix_en) begin
            if (h_q == CW'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == CW'(V_TOTAL - 1)) ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end
    end

    // Decode the *next* position so outputs line up with the counter update.
    always_comb begin
        visible_d = (h_d < CW'(H_VISIBLE)) && (v_d < CW'(V_VISIBLE));
        hs_act_d  = (h_d >= CW'(HS_START)) && (h_d < CW'(HS_END));
        vs_act_d  = (v_d >= CW'(VS_START)) && (v_d < CW'(VS_END));
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            h_q           <= CW'(H_TOTAL - 1);
            v_q           <= CW'(V_TOTAL - 1);
            x_q           <= '0;
            y_q           <= '0;
            visible_q     <= 1'b0;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            // Pulses are single-clk regardless of the enable.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (pix_en) begin
                h_q           <= h_d;
                v_q           <= v_d;
                x_q           <= h_d;
                y_q           <= v_d;
                visible_q     <= visible_d;
                hsync_q       <= hs_act_d ? HSYNC_POL : ~HSYNC_POL;
                vsync_q       <= vs_act_d ? VSYNC_POL : ~VSYNC_POL;
                line_start_q  <= (h_d == '0);
                frame_start_q <= (h_d == '0) && (v_d == '0);
            end
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.visible     = visible_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Self-checking bench: a small-parameter instance is driven with directed
//   and random pix_en/nrst and compared every clk against a linear-position
//   reference model; a default-parameter instance checks line timing.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int HV = 4, HF = 1, HS = 2, HB = 1;
    localparam int VV = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;   // 8
    localparam int VT = VV + VF + VS + VB;   // 6

    logic clk = 1'b0;
    logic nrst, pix_en;
    logic nrst_b, pix_en_b;

    always #5 clk = ~clk;

    vga_timing_if #(.CW(10)) if_s ();
    vga_timing_if #(.CW(10)) if_b ();

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CW(10)
    ) u_small (
        .clk(clk), .nrst(nrst), .pix_en(pix_en), .vga(if_s)
    );

    vga_timing_gen u_big (
        .clk(clk), .nrst(nrst_b), .pix_en(pix_en_b), .vga(if_b)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: position as a linear pixel index within the frame.
    bit m_rst = 1'b1;
    bit m_adv = 1'b0;
    int m_pos = 0;
    int cyc = 0;
    int fs_exp = 0, ls_exp = 0;
    int last_fs = -1, last_ls = -1;

    task automatic compare_all();
        int h, v, ex, ey, evis, ehs, evs, els, efs;
        if (m_rst) begin
            ex = 0; ey = 0; evis = 0; ehs = 1; evs = 1; els = 0; efs = 0;
        end else begin
            h    = m_pos % HT;
            v    = m_pos / HT;
            ex   = h;
            ey   = v;
            evis = (h < HV && v < VV) ? 1 : 0;
            ehs  = (h >= HV + HF && h < HV + HF + HS) ? 0 : 1;
            evs  = (v >= VV + VF && v < VV + VF + VS) ? 0 : 1;
            els  = (m_adv && h == 0) ? 1 : 0;
            efs  = (m_adv && m_pos == 0) ? 1 : 0;
        end
        check_eq("x", int'(if_s.x), ex);
        check_eq("y", int'(if_s.y), ey);
        check_eq("visible", int'(if_s.visible), evis);
        check_eq("hsync", int'(if_s.hsync), ehs);
        check_eq("vsync", int'(if_s.vsync), evs);
        check_eq("line_start", int'(if_s.line_start), els);
        check_eq("frame_start", int'(if_s.frame_start), efs);
    endtask

    // Called at a negedge: drive inputs, advance the model for the coming
    // posedge, then sample at the following negedge.
    task automatic step(input bit n, input bit en);
        nrst   = n;
        pix_en = en;
        if (!n) begin
            m_rst = 1'b1;
            m_adv = 1'b0;
        end else if (en) begin
            m_pos = m_rst ? 0 : (m_pos + 1) % (HT * VT);
            m_rst = 1'b0;
            m_adv = 1'b1;
        end else begin
            m_adv = 1'b0;
        end
        @(negedge clk);
        cyc++;
        compare_all();
        if (if_s.frame_start) begin
            if (last_fs >= 0 && fs_exp != 0) check_eq("fs_period", cyc - last_fs, fs_exp);
            last_fs = cyc;
        end
        if (if_s.line_start) begin
            if (last_ls >= 0 && ls_exp != 0) check_eq("ls_period", cyc - last_ls, ls_exp);
            last_ls = cyc;
        end
    endtask

    initial begin
        int guard;
        int last_fall, fall_at, prev_hs;
        nrst     = 1'b0;
        pix_en   = 1'b0;
        nrst_b   = 1'b0;
        pix_en_b = 1'b0;
        @(negedge clk);

        // Reset held, with and without enable.
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);

        // Continuous enable for three frames.
        fs_exp = HT * VT; ls_exp = HT; last_fs = -1; last_ls = -1;
        repeat (3 * HT * VT + 2) step(1'b1, 1'b1);

        // Enable every other clk.
        fs_exp = 2 * HT * VT; ls_exp = 2 * HT; last_fs = -1; last_ls = -1;
        for (int i = 0; i < 2 * 2 * HT * VT + 4; i++) step(1'b1, 1'(i % 2));
        fs_exp = 0; ls_exp = 0;

        // Reset mid-frame at (2,1), with pix_en high during the reset clk.
        guard = 0;
        while (!(m_rst == 1'b0 && m_pos == HT + 2) && guard < 200) begin
            step(1'b1, 1'b1);
            guard++;
        end
        check_eq("reach_2_1", int'(guard < 200), 1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("first_fs_after_rst", int'(if_s.frame_start), 1);
        step(1'b1, 1'b1);

        // Random enable with occasional resets.
        for (int i = 0; i < 2000; i++)
            step(($urandom % 150) != 0, ($urandom % 4) != 0);

        // Default-parameter instance: line timing.
        check_eq("big_rst_x", int'(if_b.x), 0);
        check_eq("big_rst_hsync", int'(if_b.hsync), 1);
        check_eq("big_rst_vsync", int'(if_b.vsync), 1);
        nrst_b   = 1'b1;
        pix_en_b = 1'b1;
        last_fall = -1;
        fall_at   = -1;
        prev_hs   = 1;
        for (int k = 1; k <= 2500; k++) begin
            @(negedge clk);
            check_eq("big_x", int'(if_b.x), (k - 1) % 800);
            if (prev_hs == 1 && if_b.hsync == 1'b0) begin
                check_eq("big_hs_fall_x", int'(if_b.x), 656);
                if (last_fall >= 0) check_eq("big_hs_period", k - last_fall, 800);
                last_fall = k;
                fall_at   = k;
            end
            if (prev_hs == 0 && if_b.hsync == 1'b1 && fall_at >= 0)
                check_eq("big_hs_low", k - fall_at, 96);
            prev_hs = int'(if_b.hsync);
        end
        check_eq("big_hs_seen", int'(last_fall > 0), 1);
        check_eq("big_vsync_idle", int'(if_b.vsync), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
